// File: rtl/ddr3_burst_pkg.sv
// Shared definitions for the DDR3 burst writer/checker pair: FSM states,
// default burst geometry and the per-beat test pattern.
package ddr3_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } state_e;

    localparam logic [7:0]  BURSTCNT  = 8'h80;
    localparam logic [28:0] BASE_ADDR = 29'h2400000;
    localparam logic [63:0] DATA_MASK = 64'h0000_0000_FFFF_FFFF;
    localparam int          TIMEOUT   = 1024;

    // The writer stores the beat index in byte 0 and zero elsewhere.
    function automatic logic [63:0] expected_beat(input logic [7:0] idx);
        return {56'b0, idx};
    endfunction

endpackage

// File: rtl/ddr3_burst_checker_if.sv
// Avalon-style read port toward DDRAM; the checker is the master side.
interface ddr3_burst_checker_if;

    logic        ddram_busy;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    modport master (
        input  ddram_busy,
        input  ddram_dout,
        input  ddram_dout_ready,
        output ddram_rd,
        output ddram_addr,
        output ddram_burstcnt
    );

    modport slave (
        output ddram_busy,
        output ddram_dout,
        output ddram_dout_ready,
        input  ddram_rd,
        input  ddram_addr,
        input  ddram_burstcnt
    );

endinterface

// File: rtl/ddr3_beat_checker.sv
// Compares one returned beat against the writer pattern, counts mismatching
// beats (saturating) and captures the first mismatch since reset.
module ddr3_beat_checker #(
    parameter logic [63:0] DATA_MASK = ddr3_burst_pkg::DATA_MASK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat_valid_i,
    input  logic [63:0] beat_data_i,
    input  logic [7:0]  beat_idx_i,
    output logic        mismatch_o,
    output logic [15:0] err_count_o,
    output logic [7:0]  first_err_beat_o,
    output logic [63:0] first_err_data_o
);

    logic [15:0] err_count_q;
    logic [7:0]  first_err_beat_q;
    logic [63:0] first_err_data_q;

    always_comb begin
        mismatch_o = beat_valid_i &&
            (((beat_data_i ^ ddr3_burst_pkg::expected_beat(beat_idx_i)) & DATA_MASK) != '0);
    end

    // err_count never wraps, so zero means nothing has been logged since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q      <= '0;
            first_err_beat_q <= '0;
            first_err_data_q <= '0;
        end else if (mismatch_o) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
            if (err_count_q == 16'd0) begin
                first_err_beat_q <= beat_idx_i;
                first_err_data_q <= beat_data_i;
            end
        end
    end

    assign err_count_o      = err_count_q;
    assign first_err_beat_o = first_err_beat_q;
    assign first_err_data_o = first_err_data_q;

endmodule

// File: rtl/ddr3_burst_checker.sv
// Reads back the region filled by the DDR3 burst writer in fixed-length
// bursts and reports pass/fail, error statistics and a watchdog timeout.
module ddr3_burst_checker #(
    parameter logic [7:0]  BURSTCNT  = ddr3_burst_pkg::BURSTCNT,
    parameter logic [28:0] BASE_ADDR = ddr3_burst_pkg::BASE_ADDR,
    parameter logic [63:0] DATA_MASK = ddr3_burst_pkg::DATA_MASK,
    parameter int          TIMEOUT   = ddr3_burst_pkg::TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        continuous,
    input  logic                        stop,
    ddr3_burst_checker_if.master        ddram,
    output logic                        busy,
    output logic                        pass,
    output logic [15:0]                 burst_count,
    output logic [15:0]                 err_count,
    output logic [7:0]                  first_err_beat,
    output logic [63:0]                 first_err_data,
    output logic                        timeout
);

    import ddr3_burst_pkg::*;

    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic           rd_q, rd_d;
    logic [28:0]    addr_q, addr_d;
    logic [7:0]     burstcnt_q, burstcnt_d;
    logic           pass_q, pass_d;
    logic [15:0]    burst_count_q, burst_count_d;
    logic           timeout_q, timeout_d;
    logic           stop_q, stop_d;
    logic [7:0]     beat_idx_q, beat_idx_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic           burst_err_q, burst_err_d;

    logic           beat_valid;
    logic           mismatch;

    // Beats returning while not in DATA (e.g. after a reset) are dropped here.
    assign beat_valid = (state_q == DATA) && ddram.ddram_dout_ready;

    ddr3_beat_checker #(
        .DATA_MASK (DATA_MASK)
    ) u_beat_checker (
        .clk              (clk),
        .reset            (reset),
        .beat_valid_i     (beat_valid),
        .beat_data_i      (ddram.ddram_dout),
        .beat_idx_i       (beat_idx_q),
        .mismatch_o       (mismatch),
        .err_count_o      (err_count),
        .first_err_beat_o (first_err_beat),
        .first_err_data_o (first_err_data)
    );

    always_comb begin
        // NOTE: every _d starts at its held value so no branch can infer a latch.
        state_d       = state_q;
        rd_d          = rd_q;
        addr_d        = addr_q;
        burstcnt_d    = burstcnt_q;
        pass_d        = pass_q;
        burst_count_d = burst_count_q;
        timeout_d     = timeout_q;
        stop_d        = stop_q;
        beat_idx_d    = beat_idx_q;
        wdog_d        = wdog_q;
        burst_err_d   = burst_err_q;

        if (state_q != IDLE && stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    state_d    = REQ;
                    rd_d       = 1'b1;
                    addr_d     = BASE_ADDR;
                    burstcnt_d = BURSTCNT;
                end
            end

            REQ: begin
                if (!ddram.ddram_busy) begin
                    state_d     = DATA;
                    rd_d        = 1'b0;
                    beat_idx_d  = '0;
                    wdog_d      = '0;
                    burst_err_d = 1'b0;
                end
            end

            DATA: begin
                if (beat_valid) begin
                    beat_idx_d  = beat_idx_q + 8'd1;
                    wdog_d      = '0;
                    burst_err_d = burst_err_q || mismatch;
                    if (beat_idx_q == BURSTCNT - 8'd1) begin
                        if (burst_count_q != 16'hFFFF) begin
                            burst_count_d = burst_count_q + 16'd1;
                        end
                        pass_d = !(burst_err_q || mismatch);
                        // A stop arriving on the final beat still counts.
                        if (continuous && !stop_q && !stop) begin
                            state_d = REQ;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end
                    end
                end else if (wdog_q == WD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    stop_d    = 1'b0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            burstcnt_q    <= '0;
            pass_q        <= 1'b0;
            burst_count_q <= '0;
            timeout_q     <= 1'b0;
            stop_q        <= 1'b0;
            beat_idx_q    <= '0;
            wdog_q        <= '0;
            burst_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            burstcnt_q    <= burstcnt_d;
            pass_q        <= pass_d;
            burst_count_q <= burst_count_d;
            timeout_q     <= timeout_d;
            stop_q        <= stop_d;
            beat_idx_q    <= beat_idx_d;
            wdog_q        <= wdog_d;
            burst_err_q   <= burst_err_d;
        end
    end

    assign ddram.ddram_rd       = rd_q;
    assign ddram.ddram_addr     = addr_q;
    assign ddram.ddram_burstcnt = burstcnt_q;
    assign busy                 = (state_q != IDLE);
    assign pass                 = pass_q;
    assign burst_count          = burst_count_q;
    assign timeout              = timeout_q;

endmodule

// File: doc/ddr3_burst_checker.md
Name: ddr3_burst_checker

Overview:
- Read-back stage downstream of the DDR3 burst writer: issues Avalon-style read bursts to DDRAM over the region the writer fills and checks every returned beat against the writer's pattern.
- Each burst is BURSTCNT beats; beat i is expected to hold i in byte 0 and zero in the other written bytes.
- Reports clean and failed bursts, the first mismatch and a watchdog timeout to the OSD/LED logic.
- Runs on the DDRAM clock domain.

Parameters:
- BURSTCNT, 8'h80: beats per read burst (1..255).
- BASE_ADDR, 29'h2400000: DDRAM word address of burst start.
- DATA_MASK, 64'h0000_0000_FFFF_FFFF: bits compared (writer uses BE=0x0F).
- TIMEOUT, 1024: cycles without a beat before the burst is abandoned.

Ports:
- clk  in  1  DDRAM clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a run from IDLE.
- continuous  in  1  when 1, re-issue bursts back-to-back until stop.
- stop  in  1  pulse; finish the current burst, then idle.
- ddram_busy  in  1  Avalon waitrequest.
- ddram_rd  out  1  read request.
- ddram_addr  out  29  burst address.
- ddram_burstcnt  out  8  burst length.
- ddram_dout  in  64  read data.
- ddram_dout_ready  in  1  read data valid.
- busy  out  1  high in any non-IDLE state.
- pass  out  1  last completed burst had zero mismatches.
- burst_count  out  16  completed bursts; saturates at FFFF.
- err_count  out  16  mismatching beats; saturates at FFFF.
- first_err_beat  out  8  beat index of first mismatch since reset.
- first_err_data  out  64  raw ddram_dout of first mismatch.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (sync): state IDLE; ddram_rd=0; ddram_addr=0; ddram_burstcnt=0; pass=0; timeout=0; all counters, first_err_* and internal stop latch = 0.
- States: IDLE, REQ, DATA.
- IDLE:
  - start=1 -> REQ next cycle; ddram_rd=1, ddram_addr=BASE_ADDR, ddram_burstcnt=BURSTCNT registered on the same edge.
  - ddram_dout_ready in IDLE is ignored.
- REQ:
  - rd, addr and burstcnt held stable while ddram_busy=1.
  - The cycle with rd=1 & busy=0 is the accept cycle; next edge drops rd, clears beat index and watchdog, and enters DATA.
  - rd is high for exactly (busy cycles + 1).
- DATA:
  - Each cycle with ddram_dout_ready=1: compare ((dout ^ {56'b0, beat_idx}) & DATA_MASK) != 0.
  - On mismatch: err_count+1 (saturating), burst-local error flag set. If no error has been logged since reset, capture first_err_beat=beat_idx and first_err_data=dout.
  - Then beat_idx+1 (8-bit) and watchdog cleared.
- Burst end:
  - On the beat where beat_idx==BURSTCNT-1: burst_count+1 (saturating); pass = ~(burst-local flag including this beat).
  - Next state is REQ (same address, one-cycle gap) if continuous=1 and no stop is latched; else IDLE.
- Watchdog:
  - In DATA, counts cycles without dout_ready.
  - On reaching TIMEOUT-1: timeout=1, pass=0, burst_count unchanged, state IDLE.
  - The watchdog does not run in REQ; busy stalls are unbounded.
- stop:
  - Latched in any non-IDLE state; cleared on entry to IDLE.
  - Never aborts a burst in flight.
- start while busy: ignored.
- start and stop in the same IDLE cycle: start wins and the stop latch stays clear.
- reset mid-burst: returns to IDLE and drops rd immediately. Beats still returning from the aborted burst arrive in IDLE and are ignored.
- No combinational path from inputs to outputs; every output is registered.

Decomposition:
- Package ddr3_burst_pkg:
  - state enum {IDLE, REQ, DATA};
  - default localparams BURSTCNT, BASE_ADDR, DATA_MASK, shared with the writer;
  - function expected_beat(idx) returning {56'b0, idx}.
- One sub-module, ddr3_beat_checker:
  - inputs: beat valid/data/idx;
  - owns the masked compare, err_count saturation and first-error capture;
  - outputs a mismatch strobe to the FSM.

Test Plan:
- Clean burst: start, busy=0, model returns 128 beats, values 0..127, one per cycle -> rd high exactly 1 cycle, burst_count=1, err_count=0, pass=1, busy drops 1 cycle after beat 127.
- Backpressure: busy=1 for 5 cycles on request -> rd high 6 cycles, addr=0x2400000 and burstcnt=0x80 stable throughout; beats gapped randomly (max 20 idle cycles) -> pass=1.
- Corruption:
  - beat 37 returns 0xA5 -> err_count=1, first_err_beat=37, first_err_data=0xA5, pass=0;
  - a second burst with garbage only in bits 63:32 -> err_count stays 1, pass=1.
- Timeout: model stops after 10 beats -> timeout=1 after TIMEOUT cycles, state IDLE, burst_count unchanged, pass=0; late beats in IDLE leave err_count unchanged.
- Continuous: continuous=1, stop pulsed at beat 50 of burst 3 -> burst 3 completes, burst_count=3, no 4th rd.
- Reset at beat 64: all outputs return to reset values the next cycle, remaining beats are ignored, and a fresh start passes cleanly.
